// File: rtl/clocks_pkg.sv
// Shared definitions for clock/reset infrastructure: sequencer state encoding and
// default timing parameters.
package clocks_pkg;

   typedef enum logic [2:0] {
      StPllReset = 3'd0,
      StWaitLock = 3'd1,
      StStable   = 3'd2,
      StRelease  = 3'd3,
      StRun      = 3'd4
   } seq_state_e;

   localparam int unsigned DefNStages         = 3;
   localparam int unsigned DefLockStableCycles = 1024;
   localparam int unsigned DefStageDelay      = 16;
   localparam int unsigned DefLockTimeout     = 65536;
   localparam int unsigned DefPllRstCycles    = 8;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level/status inputs; resets to zero.
module sync_2ff #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock supervisor: pulses the PLL reset, waits for stable lock, then
// releases staged downstream resets in order, dropping all of them on lock loss.
module pll_reset_sequencer
   import clocks_pkg::*;
#(
   parameter int unsigned N_STAGES           = DefNStages,
   parameter int unsigned LOCK_STABLE_CYCLES = DefLockStableCycles,
   parameter int unsigned STAGE_DELAY        = DefStageDelay,
   parameter int unsigned LOCK_TIMEOUT       = DefLockTimeout,
   parameter int unsigned PLL_RST_CYCLES     = DefPllRstCycles
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                locked,
   output logic                pll_rst,
   output logic [N_STAGES-1:0] rst_n_out,
   output logic                ready,
   output logic [7:0]          lock_loss_count,
   output logic [2:0]          state
);

   localparam int unsigned ReleaseSpan = (N_STAGES - 1) * STAGE_DELAY;
   localparam int unsigned CntMax = max_u(max_u(LOCK_STABLE_CYCLES, LOCK_TIMEOUT),
                                          max_u(PLL_RST_CYCLES, ReleaseSpan + 1));
   localparam int unsigned CntW   = $clog2(CntMax) + 1;

   localparam logic [CntW-1:0] RstLast     = CntW'(PLL_RST_CYCLES - 1);
   localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT - 1);
   localparam logic [CntW-1:0] StableLast  = CntW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CntW-1:0] ReleaseLast = CntW'(ReleaseSpan);

   logic lock_s;

   sync_2ff #(
      .WIDTH (1)
   ) u_lock_sync (
      .clk_i  (clk),
      .rst_ni (reset_n),
      .d_i    (locked),
      .q_o    (lock_s)
   );

   seq_state_e          state_q, state_d;
   logic [CntW-1:0]     cnt_q, cnt_nxt;
   logic                cnt_clr, cnt_inc;
   logic                pll_rst_q, pll_rst_d;
   logic [N_STAGES-1:0] rst_n_out_q, rst_n_out_d;
   logic                ready_q, ready_d;
   logic [7:0]          loss_q, loss_d;
   logic [N_STAGES-1:0] rel_mask;

   assign cnt_nxt = cnt_q + CntW'(1);

   // Stage k is released once the shared counter has advanced k*STAGE_DELAY past entry.
   always_comb begin
      rel_mask = '0;
      for (int unsigned k = 0; k < N_STAGES; k++) begin
         rel_mask[k] = (cnt_nxt >= CntW'(k * STAGE_DELAY));
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_clr     = 1'b0;
      cnt_inc     = 1'b0;
      pll_rst_d   = 1'b0;
      rst_n_out_d = '0;
      ready_d     = 1'b0;
      loss_d      = loss_q;

      unique case (state_q)
         StPllReset: begin
            if (cnt_q == RstLast) begin
               state_d = StWaitLock;
               cnt_clr = 1'b1;
            end else begin
               pll_rst_d = 1'b1;
               cnt_inc   = 1'b1;
            end
         end
         StWaitLock: begin
            if (lock_s) begin
               state_d = StStable;
               cnt_clr = 1'b1;
            end else if (cnt_q == TimeoutLast) begin
               state_d   = StPllReset;
               pll_rst_d = 1'b1;
               cnt_clr   = 1'b1;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         StStable: begin
            if (!lock_s) begin
               state_d = StWaitLock;
               cnt_clr = 1'b1;
            end else if (cnt_q == StableLast) begin
               state_d     = StRelease;
               cnt_clr     = 1'b1;
               rst_n_out_d = N_STAGES'(1);
            end else begin
               cnt_inc = 1'b1;
            end
         end
         StRelease, StRun: begin
            if (!lock_s) begin
               state_d = StWaitLock;
               cnt_clr = 1'b1;
               loss_d  = (loss_q == 8'hFF) ? 8'hFF : loss_q + 8'd1;
            end else if (state_q == StRun || cnt_q == ReleaseLast) begin
               state_d     = StRun;
               cnt_clr     = 1'b1;
               rst_n_out_d = '1;
               ready_d     = 1'b1;
            end else begin
               cnt_inc     = 1'b1;
               rst_n_out_d = rel_mask;
            end
         end
         default: begin
            state_d   = StPllReset;
            pll_rst_d = 1'b1;
            cnt_clr   = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StPllReset;
         pll_rst_q   <= 1'b1;
         rst_n_out_q <= '0;
         ready_q     <= 1'b0;
         loss_q      <= 8'd0;
      end else begin
         state_q     <= state_d;
         pll_rst_q   <= pll_rst_d;
         rst_n_out_q <= rst_n_out_d;
         ready_q     <= ready_d;
         loss_q      <= loss_d;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else if (cnt_clr) begin
         cnt_q <= '0;
      end else if (cnt_inc) begin
         cnt_q <= cnt_nxt;
      end
   end

   assign pll_rst         = pll_rst_q;
   assign rst_n_out       = rst_n_out_q;
   assign ready           = ready_q;
   assign lock_loss_count = loss_q;
   assign state           = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench: stimulus queues each expected output change with its cycle offset;
// the monitor compares every observed change against the queue head.
module tb_pll_reset_sequencer;
   import clocks_pkg::*;

   localparam int unsigned NSt = 3;

   logic           clk = 1'b0;
   logic           reset_n;
   logic           locked;
   logic           pll_rst;
   logic [NSt-1:0] rst_n_out;
   logic           ready;
   logic [7:0]     lock_loss_count;
   logic [2:0]     state;

   always #5 clk = ~clk;

   pll_reset_sequencer #(
      .N_STAGES           (NSt),
      .LOCK_STABLE_CYCLES (8),
      .STAGE_DELAY        (4),
      .LOCK_TIMEOUT       (32),
      .PLL_RST_CYCLES     (4)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .locked          (locked),
      .pll_rst         (pll_rst),
      .rst_n_out       (rst_n_out),
      .ready           (ready),
      .lock_loss_count (lock_loss_count),
      .state           (state)
   );

   typedef struct {
      logic [15:0] vec;
      int          dt;
   } exp_t;

   exp_t exp_q[$];
   int   cyc      = 0;
   int   mark_cyc = 0;
   int   n_cmp    = 0;
   int   n_bad    = 0;
   bit   done     = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic push(input logic [2:0] st, input logic p, input logic [2:0] r,
                       input logic rd, input logic [7:0] c, input int dt);
      exp_t e;
      e.vec = {st, p, r, rd, c};
      e.dt  = dt;
      exp_q.push_back(e);
   endtask

   task automatic mark();
      mark_cyc = cyc;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // Queues the full sequence seen after reset release with locked held high.
   task automatic push_clean_release();
      push(StWaitLock, 1'b0, 3'b000, 1'b0, 8'd0, 4);
      push(StStable,   1'b0, 3'b000, 1'b0, 8'd0, 1);
      push(StRelease,  1'b0, 3'b001, 1'b0, 8'd0, 8);
      push(StRelease,  1'b0, 3'b011, 1'b0, 8'd0, 4);
      push(StRelease,  1'b0, 3'b111, 1'b0, 8'd0, 4);
      push(StRun,      1'b0, 3'b111, 1'b1, 8'd0, 1);
   endtask

   // Monitor
   initial begin
      logic [15:0] obs, prev;
      int          last_cyc, refc, delta, nchg;
      exp_t        e;
      prev     = '1;
      last_cyc = 0;
      nchg     = 0;
      while (!done) begin
         @(negedge clk or negedge reset_n);
         #1;
         obs = {state, pll_rst, rst_n_out, ready, lock_loss_count};
         if (obs !== prev) begin
            refc  = (mark_cyc > last_cyc) ? mark_cyc : last_cyc;
            delta = cyc - refc;
            nchg++;
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL chg%0d unexpected: got st=%0d pll=%b rst=%b rdy=%b cnt=%0d, required no change",
                        nchg, obs[15:13], obs[12], obs[11:9], obs[8], obs[7:0]);
            end else begin
               e = exp_q.pop_front();
               if (obs !== e.vec) begin
                  n_bad++;
                  $display("FAIL chg%0d value: got st=%0d pll=%b rst=%b rdy=%b cnt=%0d, required st=%0d pll=%b rst=%b rdy=%b cnt=%0d",
                           nchg, obs[15:13], obs[12], obs[11:9], obs[8], obs[7:0],
                           e.vec[15:13], e.vec[12], e.vec[11:9], e.vec[8], e.vec[7:0]);
               end
               if (e.dt >= 0) begin
                  n_cmp++;
                  if (delta != e.dt) begin
                     n_bad++;
                     $display("FAIL chg%0d timing: got %0d cycles, required %0d", nchg, delta, e.dt);
                  end
               end
            end
            prev     = obs;
            last_cyc = cyc;
         end
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL pending: got %0d unseen expected changes, required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Stimulus
   initial begin
      int c;
      reset_n = 1'b0;
      locked  = 1'b0;
      push(StPllReset, 1'b1, 3'b000, 1'b0, 8'd0, -1);

      // No lock: PLL reset re-pulses every 4+32 cycles
      step(3);
      mark();
      reset_n = 1'b1;
      push(StWaitLock, 1'b0, 3'b000, 1'b0, 8'd0, 4);
      push(StPllReset, 1'b1, 3'b000, 1'b0, 8'd0, 32);
      push(StWaitLock, 1'b0, 3'b000, 1'b0, 8'd0, 4);
      push(StPllReset, 1'b1, 3'b000, 1'b0, 8'd0, 32);
      push(StWaitLock, 1'b0, 3'b000, 1'b0, 8'd0, 4);
      step(80);
      mark();
      reset_n = 1'b0;
      locked  = 1'b1;
      push(StPllReset, 1'b1, 3'b000, 1'b0, 8'd0, 0);

      // One-cycle glitch during STABLE restarts the stability count
      step(3);
      mark();
      reset_n = 1'b1;
      push(StWaitLock, 1'b0, 3'b000, 1'b0, 8'd0, 4);
      push(StStable,   1'b0, 3'b000, 1'b0, 8'd0, 1);
      push(StWaitLock, 1'b0, 3'b000, 1'b0, 8'd0, 5);
      push(StStable,   1'b0, 3'b000, 1'b0, 8'd0, 1);
      push(StRelease,  1'b0, 3'b001, 1'b0, 8'd0, 8);
      push(StRelease,  1'b0, 3'b011, 1'b0, 8'd0, 4);
      push(StRelease,  1'b0, 3'b111, 1'b0, 8'd0, 4);
      push(StRun,      1'b0, 3'b111, 1'b1, 8'd0, 1);
      step(7);
      locked = 1'b0;
      step(1);
      locked = 1'b1;
      step(25);

      // Lock loss in RUN, then full re-sequence
      mark();
      locked = 1'b0;
      push(StWaitLock, 1'b0, 3'b000, 1'b0, 8'd1, 3);
      step(4);
      mark();
      locked = 1'b1;
      push(StStable,   1'b0, 3'b000, 1'b0, 8'd1, 3);
      push(StRelease,  1'b0, 3'b001, 1'b0, 8'd1, 8);
      push(StRelease,  1'b0, 3'b011, 1'b0, 8'd1, 4);
      push(StRelease,  1'b0, 3'b111, 1'b0, 8'd1, 4);
      push(StRun,      1'b0, 3'b111, 1'b1, 8'd1, 1);
      step(25);

      // Lock loss after bit 1, landing on the edge bit 2 would have been released
      mark();
      locked = 1'b0;
      push(StWaitLock, 1'b0, 3'b000, 1'b0, 8'd2, 3);
      step(4);
      mark();
      locked = 1'b1;
      push(StStable,   1'b0, 3'b000, 1'b0, 8'd2, 3);
      push(StRelease,  1'b0, 3'b001, 1'b0, 8'd2, 8);
      push(StRelease,  1'b0, 3'b011, 1'b0, 8'd2, 4);
      step(16);
      mark();
      locked = 1'b0;
      push(StWaitLock, 1'b0, 3'b000, 1'b0, 8'd3, 3);
      step(4);

      // Repeated losses in RELEASE drive the counter into saturation
      c = 3;
      for (int i = 0; i < 256; i++) begin
         mark();
         locked = 1'b1;
         push(StStable,  1'b0, 3'b000, 1'b0, 8'(c), 3);
         push(StRelease, 1'b0, 3'b001, 1'b0, 8'(c), 8);
         step(12);
         mark();
         locked = 1'b0;
         c = (c == 255) ? 255 : c + 1;
         push(StWaitLock, 1'b0, 3'b000, 1'b0, 8'(c), 3);
         step(4);
      end

      // Asynchronous reset mid-RELEASE, then clean restart
      mark();
      locked = 1'b1;
      push(StStable,  1'b0, 3'b000, 1'b0, 8'd255, 3);
      push(StRelease, 1'b0, 3'b001, 1'b0, 8'd255, 8);
      push(StRelease, 1'b0, 3'b011, 1'b0, 8'd255, 4);
      step(16);
      mark();
      reset_n = 1'b0;
      push(StPllReset, 1'b1, 3'b000, 1'b0, 8'd0, 0);
      step(3);
      mark();
      reset_n = 1'b1;
      push_clean_release();
      step(25);
      done = 1'b1;
   end

endmodule
